ppu_vram_arbiter: RTL and testbench
===================================

Name: ppu_vram_arbiter

Overview:
Shares the single-port PPU VRAM between two requesters: the background/sprite render fetch path and the CPU register interface (PPUDATA reads and writes).
- The renderer has priority while rendering is active.
- CPU accesses are held in a one-entry pending buffer and serviced in free slots.
- A starvation counter forces a CPU slot when the renderer monopolises the port.
- Sits between the render/register blocks and the VRAM instance, replacing the static address mux.

Parameters:
ADDR_W, 16, VRAM address width
DATA_W, 8, VRAM data width
STARVE_MAX, 8, max cycles a pending CPU access waits before a forced grant (0 = CPU always wins)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
render_active  in  1  high during visible/prefetch scanlines with rendering enabled
ren_req  in  1  renderer fetch request (reads only)
ren_addr  in  ADDR_W  renderer fetch address
ren_gnt  out  1  renderer owns VRAM this cycle
ren_rvalid  out  1  ren_rdata valid (1 cycle after ren_gnt)
ren_rdata  out  DATA_W  renderer read data
cpu_req  in  1  CPU access strobe (single cycle)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU access address
cpu_wdata  in  DATA_W  CPU write data
cpu_busy  out  1  pending CPU access not yet completed
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_done
vram_addr  out  ADDR_W  VRAM address
vram_we  out  1  VRAM write enable
vram_wdata  out  DATA_W  VRAM write data
vram_rdata  in  DATA_W  VRAM read data (synchronous, 1-cycle latency)

Behaviour:
- States: IDLE (no CPU pending) and PEND (CPU access latched).
- Reset (asynchronous): state IDLE, starve_cnt 0. All outputs 0: cpu_busy, cpu_done, ren_gnt, ren_rvalid, vram_we, vram_addr, and both rdata registers.
- Accept:
  - In IDLE, cpu_req=1 latches cpu_we/addr/wdata into the pending buffer; state becomes PEND and cpu_busy=1 from the next cycle.
  - cpu_req while cpu_busy=1 is ignored (no overwrite).
  - Earliest grant is the cycle after accept.
- Arbitration (combinational, each cycle):
  - CPU wins if PEND and any of: render_active=0, ren_req=0, or starve_cnt>=STARVE_MAX.
  - Otherwise the renderer wins if ren_req=1.
  - Otherwise idle: vram_we=0 and vram_addr holds its last value.
- Grant effects:
  - Renderer grant: ren_gnt=1 and vram_addr=ren_addr in the same cycle.
  - CPU grant: vram_addr=pending addr; for writes, vram_we=1 and vram_wdata=pending data for exactly one cycle.
  - ren_gnt=0 whenever the CPU is granted; the renderer must hold ren_req/ren_addr until granted.
- Read return:
  - ren_rvalid registered 1 cycle after ren_gnt, with ren_rdata=vram_rdata.
  - cpu_done registered 1 cycle after CPU grant (reads and writes). For reads, cpu_rdata=vram_rdata and holds until the next CPU read completes.
  - cpu_busy falls in the cycle cpu_done rises; a new cpu_req is accepted that same cycle.
- starve_cnt:
  - Increments each cycle in PEND without a CPU grant, saturating at STARVE_MAX.
  - Clears on CPU grant.
  - Held at 0 in IDLE.
- Boundaries:
  - render_active changing mid-access does not affect an in-flight read return.
  - Back-to-back renderer grants every cycle are legal, with one rvalid per grant.
  - STARVE_MAX=0: a pending CPU access is granted on the first cycle after accept regardless of ren_req.
  - Reset asserted mid-access drops the pending access and suppresses any rvalid/done.

Optional Feature:
PPU_ARB_STATS_EN
- Defined: adds output conflict_cnt [15:0] (port exists only when defined).
- Increments by 1 each cycle both ren_req=1 and PEND are true, saturating at 16'hFFFF.
- Cleared by reset and on the rising edge of render_active.
- Undefined: no counter and no port; arbitration behaviour is identical.

Test Plan:
1. render_active=0, CPU write addr 16'h2000 data 8'h5A -> next cycle vram_we=1, vram_addr=16'h2000, vram_wdata=8'h5A; cpu_done one cycle later; cpu_busy then 0.
2. render_active=1, ren_req held high continuously, CPU read 16'h23C0, STARVE_MAX=8 -> ren_gnt low for exactly one cycle after 8 waiting cycles; cpu_done next cycle with cpu_rdata=VRAM[16'h23C0].
3. render_active=1, ren_req toggling 1,0 with a CPU read pending -> CPU granted in the first ren_req=0 cycle, starve_cnt cleared, renderer rvalid sequence uninterrupted.
4. Second cpu_req while cpu_busy=1 (addr 16'h2400, data 8'hFF) -> ignored; only the first access reaches VRAM; exactly one cpu_done.
5. reset asserted in the cycle after a CPU read grant -> cpu_done never pulses; all outputs 0 immediately; state IDLE after release.
6. With PPU_ARB_STATS_EN, 5 cycles of simultaneous ren_req and PEND -> conflict_cnt=5; cleared to 0 on the next render_active rise.

Source files
------------

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: shares the single-port PPU VRAM between renderer fetches and CPU PPUDATA accesses.
// Ports: render_active/ren_* renderer side (grant same cycle, rvalid 1 cycle later); cpu_* register side
// with a one-entry pending buffer (busy while held, done pulse 1 cycle after grant); vram_* to the RAM.
// Latency: grant is combinational; read data and completions return 1 cycle after the grant.
// Backpressure: the renderer holds ren_req/ren_addr until ren_gnt; CPU strobes are dropped while cpu_busy.
// Optional: define PPU_ARB_STATS_EN to add the conflict_cnt[15:0] output.
module ppu_vram_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              render_active,
   input  logic              ren_req,
   input  logic [ADDR_W-1:0] ren_addr,
   output logic              ren_gnt,
   output logic              ren_rvalid,
   output logic [DATA_W-1:0] ren_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_busy,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [DATA_W-1:0] vram_wdata,
   input  logic [DATA_W-1:0] vram_rdata
`ifdef PPU_ARB_STATS_EN
   ,
   output logic [15:0]       conflict_cnt
`endif
);

   // Counter must be able to hold STARVE_MAX itself; keep at least one bit for STARVE_MAX=0.
   localparam int               CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              pend_we_q;
   logic [ADDR_W-1:0] pend_addr_q;
   logic [DATA_W-1:0] pend_wdata_q;
   logic [ADDR_W-1:0] addr_q;
   logic              cpu_done_q, cpu_rd_done_q, ren_rvalid_q;
   logic [DATA_W-1:0] cpu_rdata_q, ren_rdata_q;
   logic              cpu_win, ren_win, accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      cpu_win    = 1'b0;
      ren_win    = 1'b0;
      accept     = 1'b0;
      ren_gnt    = 1'b0;
      vram_we    = 1'b0;
      vram_wdata = '0;
      vram_addr  = addr_q;

      // Grants are forced off while reset is held so the RAM sees no access.
      if (!reset) begin
         cpu_win = (state_q == PEND) &&
                   (!render_active || !ren_req || (starve_q >= STARVE_LIM));
         ren_win = !cpu_win && ren_req;
      end

      case (state_q)
         IDLE: begin
            starve_d = '0;
            if (cpu_req) begin
               accept  = 1'b1;
               state_d = PEND;
            end
         end
         PEND: begin
            if (cpu_win) begin
               state_d  = IDLE;
               starve_d = '0;
            end else if (starve_q < STARVE_LIM) begin
               starve_d = starve_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (cpu_win) begin
         vram_addr = pend_addr_q;
         vram_we   = pend_we_q;
         if (pend_we_q) vram_wdata = pend_wdata_q;
      end else if (ren_win) begin
         vram_addr = ren_addr;
         ren_gnt   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q      <= '0;
         pend_we_q     <= 1'b0;
         pend_addr_q   <= '0;
         pend_wdata_q  <= '0;
         addr_q        <= '0;
         cpu_done_q    <= 1'b0;
         cpu_rd_done_q <= 1'b0;
         ren_rvalid_q  <= 1'b0;
         cpu_rdata_q   <= '0;
         ren_rdata_q   <= '0;
      end else begin
         starve_q      <= starve_d;
         addr_q        <= vram_addr;
         if (accept) begin
            pend_we_q    <= cpu_we;
            pend_addr_q  <= cpu_addr;
            pend_wdata_q <= cpu_wdata;
         end
         cpu_done_q    <= cpu_win;
         cpu_rd_done_q <= cpu_win && !pend_we_q;
         ren_rvalid_q  <= ren_win;
         // RAM data arrives in the completion cycle; capture it so it holds afterwards.
         if (cpu_rd_done_q) cpu_rdata_q <= vram_rdata;
         if (ren_rvalid_q)  ren_rdata_q <= vram_rdata;
      end
   end

   assign cpu_busy   = (state_q == PEND);
   assign cpu_done   = cpu_done_q;
   assign ren_rvalid = ren_rvalid_q;
   // Bypass the RAM output during the completion cycle, then present the held copy.
   assign cpu_rdata  = cpu_rd_done_q ? vram_rdata : cpu_rdata_q;
   assign ren_rdata  = ren_rvalid_q  ? vram_rdata : ren_rdata_q;

`ifdef PPU_ARB_STATS_EN
   logic        ra_q;
   logic [15:0] conflict_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ra_q       <= 1'b0;
         conflict_q <= '0;
      end else begin
         ra_q <= render_active;
         if (render_active && !ra_q)
            conflict_q <= '0;
         else if (ren_req && (state_q == PEND) && (conflict_q != 16'hFFFF))
            conflict_q <= conflict_q + 16'd1;
      end
   end

   assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
module tb_ppu_vram_arbiter;

   localparam int STARVE = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        render_active, ren_req, cpu_req, cpu_we;
   logic [15:0] ren_addr, cpu_addr, vram_addr;
   logic [7:0]  cpu_wdata, vram_wdata, vram_rdata, ren_rdata, cpu_rdata;
   logic        ren_gnt, ren_rvalid, cpu_busy, cpu_done, vram_we;
`ifdef PPU_ARB_STATS_EN
   logic [15:0] conflict_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ppu_vram_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(STARVE)) dut (
      .clk(clk), .reset(reset), .render_active(render_active),
      .ren_req(ren_req), .ren_addr(ren_addr), .ren_gnt(ren_gnt),
      .ren_rvalid(ren_rvalid), .ren_rdata(ren_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
      .vram_rdata(vram_rdata)
`ifdef PPU_ARB_STATS_EN
      , .conflict_cnt(conflict_cnt)
`endif
   );

   // VRAM model: synchronous read, 1-cycle latency; unwritten locations hold a fixed pattern.
   logic [7:0] vmem    [logic [15:0]];
   logic [7:0] ref_mem [logic [15:0]];

   function automatic logic [7:0] init_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction
   function automatic logic [7:0] vmem_rd(input logic [15:0] a);
      if (vmem.exists(a)) return vmem[a];
      return init_val(a);
   endfunction
   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   always @(posedge clk) begin
      vram_rdata <= vmem_rd(vram_addr);
      if (vram_we) vmem[vram_addr] = vram_wdata;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ren_gnt"},    ren_gnt,    0);
      chk({nm, "_ren_rvalid"}, ren_rvalid, 0);
      chk({nm, "_ren_rdata"},  ren_rdata,  0);
      chk({nm, "_cpu_busy"},   cpu_busy,   0);
      chk({nm, "_cpu_done"},   cpu_done,   0);
      chk({nm, "_cpu_rdata"},  cpu_rdata,  0);
      chk({nm, "_vram_we"},    vram_we,    0);
      chk({nm, "_vram_addr"},  vram_addr,  0);
   endtask

   typedef struct {
      logic        ra;
      logic        rr;
      logic        we;
      logic [15:0] raddr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          exp_wait;   // cycles from accept to CPU grant
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t v, input string nm);
      render_active = v.ra; ren_req = v.rr; ren_addr = v.raddr;
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      smp();
      chk({nm, "_busy_accept"}, cpu_busy, 0);
      step();
      cpu_req = 1'b0;
      for (int w = 1; w <= v.exp_wait; w++) begin
         smp();
         chk({nm, "_busy_wait"}, cpu_busy, 1);
         if (w < v.exp_wait) begin
            chk({nm, "_ren_gnt_wait"}, ren_gnt, v.rr);
            chk({nm, "_we_wait"}, vram_we, 0);
         end else begin
            chk({nm, "_ren_gnt_cpu"}, ren_gnt, 0);
            chk({nm, "_addr_cpu"}, vram_addr, v.addr);
            chk({nm, "_we_cpu"}, vram_we, v.we);
            if (v.we) chk({nm, "_wdata_cpu"}, vram_wdata, v.wdata);
         end
         step();
      end
      smp();
      chk({nm, "_done"}, cpu_done, 1);
      chk({nm, "_busy_done"}, cpu_busy, 0);
      chk({nm, "_ren_gnt_after"}, ren_gnt, v.rr);
      if (!v.we) chk({nm, "_cpu_rdata"}, cpu_rdata, ref_rd(v.addr));
      else ref_mem[v.addr] = v.wdata;
      step();
      ren_req = 1'b0;
      smp();
      chk({nm, "_done_once"}, cpu_done, 0);
      step();
   endtask

   // Reference model state for the randomized phase.
   bit          m_pend, m_we, m_done, m_done_rd, m_rv, m_ren_win, m_addr_known, m_rd_known;
   bit          cw, rw, pend0;
   int          m_wait;
   logic [15:0] m_addr, m_last, exp_addr;
   logic [7:0]  m_wdata, m_done_data, m_rv_data, m_cpu_rdata;
   int          we_cnt, done_cnt;
   vec_t        rb;

   initial begin
      vecs[0] = '{ra:1'b0, rr:1'b1, we:1'b1, raddr:16'h0100, addr:16'h2000, wdata:8'h5A, exp_wait:1};
      vecs[1] = '{ra:1'b1, rr:1'b1, we:1'b0, raddr:16'h0101, addr:16'h23C0, wdata:8'h00, exp_wait:STARVE+1};
      vecs[2] = '{ra:1'b1, rr:1'b0, we:1'b0, raddr:16'h0102, addr:16'h2000, wdata:8'h00, exp_wait:1};
      vecs[3] = '{ra:1'b0, rr:1'b0, we:1'b1, raddr:16'h0103, addr:16'h3F00, wdata:8'h11, exp_wait:1};
      vecs[4] = '{ra:1'b1, rr:1'b1, we:1'b1, raddr:16'h0104, addr:16'h2400, wdata:8'h77, exp_wait:STARVE+1};

      reset = 1'b1; render_active = 1'b1; ren_req = 1'b1; ren_addr = 16'h1234;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      smp(); smp();
      chk_all_zero("reset");
      step();
      reset = 1'b0; ren_req = 1'b0;
      step();

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Renderer toggling with a CPU read pending: CPU takes the first free slot.
      render_active = 1'b1; ren_req = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2105;
      smp(); chk("tog_busy0", cpu_busy, 0);
      step(); cpu_req = 1'b0; ren_req = 1'b1; ren_addr = 16'h0040;
      smp(); chk("tog_ren_gnt1", ren_gnt, 1); chk("tog_addr1", vram_addr, 16'h0040);
      step(); ren_req = 1'b0;
      smp(); chk("tog_ren_gnt2", ren_gnt, 0); chk("tog_addr2", vram_addr, 16'h2105);
      chk("tog_rvalid2", ren_rvalid, 1); chk("tog_rdata2", ren_rdata, ref_rd(16'h0040));
      step(); ren_req = 1'b1; ren_addr = 16'h0041;
      smp(); chk("tog_done3", cpu_done, 1); chk("tog_cpu_rdata3", cpu_rdata, ref_rd(16'h2105));
      chk("tog_ren_gnt3", ren_gnt, 1); chk("tog_rvalid3", ren_rvalid, 0);
      step(); ren_req = 1'b0;
      smp(); chk("tog_rvalid4", ren_rvalid, 1); chk("tog_rdata4", ren_rdata, ref_rd(16'h0041));
      chk("tog_cpu_rdata_hold", cpu_rdata, ref_rd(16'h2105));
      step();

      // Second strobe while busy must be dropped.
      render_active = 1'b0; ren_req = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2010; cpu_wdata = 8'h33;
      step(); cpu_addr = 16'h2400; cpu_wdata = 8'hFF;
      we_cnt = 0; done_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         smp();
         if (vram_we) begin
            we_cnt++;
            chk("busy_ign_addr", vram_addr, 16'h2010);
            chk("busy_ign_wdata", vram_wdata, 8'h33);
         end
         if (cpu_done) done_cnt++;
         step(); cpu_req = 1'b0;
      end
      chk("busy_ign_we_cnt", we_cnt, 1);
      chk("busy_ign_done_cnt", done_cnt, 1);
      ref_mem[16'h2010] = 8'h33;
      rb = '{ra:1'b0, rr:1'b0, we:1'b0, raddr:16'h0, addr:16'h2400, wdata:8'h0, exp_wait:1};
      run_vec(rb, "busy_ign_rb2400");

      // Reset in the cycle after a CPU read grant.
      render_active = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2200;
      step(); cpu_req = 1'b0;
      smp(); chk("rst_grant_addr", vram_addr, 16'h2200);
      step(); reset = 1'b1; ren_req = 1'b1; ren_addr = 16'h0777;
      smp(); chk_all_zero("rst_mid");
      step(); reset = 1'b0; ren_req = 1'b0;
      smp(); chk("rst_rel_busy", cpu_busy, 0); chk("rst_rel_done", cpu_done, 0);
      step();
      smp(); chk("rst_rel_done2", cpu_done, 0); chk("rst_rel_rvalid", ren_rvalid, 0);
      step();
      rb = '{ra:1'b0, rr:1'b0, we:1'b0, raddr:16'h0, addr:16'h2200, wdata:8'h0, exp_wait:1};
      run_vec(rb, "rst_after");

`ifdef PPU_ARB_STATS_EN
      render_active = 1'b0; ren_req = 1'b0;
      step();
      render_active = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2300;
      step(); cpu_req = 1'b0; ren_req = 1'b1; ren_addr = 16'h0200;
      repeat (5) step();
      ren_req = 1'b0;
      step();
      smp(); chk("stats_done", cpu_done, 1); chk("stats_cnt5", conflict_cnt, 5);
      step(); render_active = 1'b0;
      step(); render_active = 1'b1;
      step();
      smp(); chk("stats_clear", conflict_cnt, 0);
      step();
`endif

      // Randomized traffic against the reference model.
      render_active = 1'b1; ren_req = 1'b0; cpu_req = 1'b0;
      step(); step();
      m_pend = 0; m_wait = 0; m_done = 0; m_done_rd = 0; m_rv = 0;
      m_ren_win = 0; m_addr_known = 0; m_rd_known = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         if ($urandom_range(0, 15) == 0) render_active = ~render_active;
         if (!(ren_req && !m_ren_win)) begin
            ren_req  = ($urandom_range(0, 3) != 0);
            ren_addr = 16'h2000 | 16'($urandom_range(0, 63));
         end
         cpu_req   = ($urandom_range(0, 4) == 0);
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_addr  = 16'h2000 | 16'($urandom_range(0, 63));
         cpu_wdata = 8'($urandom);
         smp();
         pend0 = m_pend;
         cw = m_pend && (!render_active || !ren_req || m_wait >= STARVE);
         rw = !cw && ren_req;
         exp_addr = cw ? m_addr : (rw ? ren_addr : m_last);
         if (m_done_rd) begin
            m_cpu_rdata = m_done_data;
            m_rd_known  = 1;
         end
         chk("r_ren_gnt", ren_gnt, rw);
         chk("r_vram_we", vram_we, cw && m_we);
         chk("r_busy", cpu_busy, m_pend);
         chk("r_done", cpu_done, m_done);
         chk("r_rvalid", ren_rvalid, m_rv);
         if (cw || rw || m_addr_known) chk("r_vram_addr", vram_addr, exp_addr);
         if (cw && m_we) chk("r_vram_wdata", vram_wdata, m_wdata);
         if (m_rd_known) chk("r_cpu_rdata", cpu_rdata, m_cpu_rdata);
         if (m_rv) chk("r_ren_rdata", ren_rdata, m_rv_data);

         if (cw || rw) begin
            m_last = exp_addr;
            m_addr_known = 1;
         end
         m_done    = cw;
         m_done_rd = cw && !m_we;
         if (cw && !m_we) m_done_data = ref_rd(m_addr);
         m_rv = rw;
         if (rw) m_rv_data = ref_rd(ren_addr);
         if (cw && m_we) ref_mem[m_addr] = m_wdata;
         if (cw) begin
            m_pend = 0;
            m_wait = 0;
         end else if (m_pend && m_wait < STARVE) begin
            m_wait++;
         end
         if (!pend0 && cpu_req) begin
            m_pend = 1; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
         end
         m_ren_win = rw;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
